mb_valid_pattern_generator: RTL and testbench
=============================================

// Module: mb_valid_pattern_generator
// PURPOSE
//  Mainband valid-lane transmitter. Drives 32-bit words (32 UI per clock) onto the TX valid lane.
//  - Training: emits VALTRAIN bursts for the receiver's Pattern-valid checks (ITER_128 error-count mode, CONSEC_16 mode).
//  - Mission mode: marks each data-valid cycle with the per-frame valid pattern.
//  Sits beside the mainband data serializer and is controlled by the MBTRAIN/valid-training FSM.
// PARAMETERS
//  ITER_128_CNT   128  VALTRAIN iterations (8 UI each) sent in ITER_128 mode; must be a multiple of 4
//  ITER_CONS_CNT  16   VALTRAIN iterations sent in CONSEC_16 mode; must be a multiple of 4
// PORTS
//  i_clk              input   1   system clock (single clock domain)
//  i_rst_n            input   1   asynchronous, active-low reset
//  i_enable_generator input   1   start/hold training burst; low aborts or releases the burst
//  i_enable_128       input   1   mode select bit: {i_enable_cons,i_enable_128}=01 selects ITER_128
//  i_enable_cons      input   1   mode select bit: 10 selects CONSEC_16; 00/11 are invalid
//  i_data_valid       input   1   mission-mode data valid for this 32-UI frame
//  o_TVLD_L           output  32  TX valid-lane word; bit 0 = first UI, same mapping as the receiver
//  o_busy             output  1   high while a burst is being transmitted
//  o_done             output  1   burst complete; held until i_enable_generator is low
// BEHAVIOUR
//  - Constant VALID_PATTERN = 32'hF0F0_F0F0, i.e. byte 8'b1111_0000 repeated (one VALTRAIN iteration per byte).
//  - All outputs are registered.
//  - Reset values: o_TVLD_L=0, o_busy=0, o_done=0. FSM=IDLE, word counter=0, latched mode=00.
//  - Words per burst: W = CNT/4.
//    - ITER_128: W = ITER_128_CNT/4 (32 words at default).
//    - CONSEC_16: W = ITER_CONS_CNT/4 (4 words at default).
//  - Word counter is 6 bits (max 63 words); it resets to 0 on every entry to SEND.
//  - FSM states and transitions:
//    - IDLE:
//      - If i_enable_generator=1 and mode is 01 or 10: latch mode, go to SEND.
//      - If mode is 00 or 11: stay in IDLE and start nothing.
//      - Otherwise o_TVLD_L <= i_data_valid ? VALID_PATTERN : 0.
//    - SEND:
//      - o_TVLD_L <= VALID_PATTERN every cycle; o_busy=1; counter increments.
//      - After the word with count == W-1, go to DONE.
//      - Mode inputs are ignored while in SEND; the latched mode is used.
//    - DONE:
//      - o_TVLD_L <= 0, o_busy=0, o_done=1.
//      - When i_enable_generator=0: go to IDLE and clear o_done the following cycle.
//  - Latency and timing:
//    - Enable sampled high in IDLE at edge N: first pattern word is visible after edge N+1.
//    - Exactly W consecutive pattern words are driven.
//    - o_done rises in the cycle immediately after the last word, with no gap cycle.
//  - Abort: i_enable_generator=0 during SEND -> next edge returns to IDLE, o_TVLD_L=0, o_busy=0, o_done stays 0, counter cleared.
//  - Priority: i_data_valid is ignored in SEND and in DONE; training has priority over mission data.
//  - Restart: a new burst needs enable to go low (DONE->IDLE) and then high again. No back-to-back burst without one IDLE cycle.
//  - Reset asserted mid-burst: all outputs return to reset values immediately, no partial done.
// CONFIGURATION
//  - Optional macro VALID_ERR_INJECT_EN adds two inputs:
//    - i_inject_err (1): error-injection request.
//    - i_inject_bit (5): index of the bit to flip.
//  - Behaviour with the macro defined:
//    - A pulse on i_inject_err while in SEND flips o_TVLD_L[i_inject_bit] in the next transmitted pattern word only.
//    - A pulse outside SEND is dropped.
//    - Only one injection can be pending; further pulses while pending are ignored.
//    - The word count is unchanged.
//  - Without the macro: ports and logic are absent; pattern words are always exact.
// TESTING
//  1. Reset; mode=01, enable=1 -> 32 cycles of 32'hF0F0F0F0, o_busy=1; then o_done=1, o_TVLD_L=0.
//  2. Mode=10, enable=1 -> exactly 4 pattern words, then o_done; drop enable -> o_done=0 one cycle later.
//  3. Enable=1 with mode=11 (or 00) -> stays IDLE; o_busy=0, o_done=0, o_TVLD_L=0 for 50 cycles.
//  4. ITER_128 burst, enable dropped after word 10 -> o_TVLD_L=0, o_busy=0, o_done never asserts.
//     Re-enable -> full 32 words.
//  5. IDLE with i_data_valid toggling 1,0,1 -> o_TVLD_L = F0F0F0F0, 0, F0F0F0F0, one cycle later each.
//     i_data_valid=1 during SEND has no effect.
//  6. With VALID_ERR_INJECT_EN: inject bit 4 at word 5 of an ITER_128 burst -> that word is 32'hF0F0F0E0, all others exact.
//     Paired receiver error_counter = 1.

Source files
------------

// File: rtl/mb_valid_pattern_generator.sv
// -----------------------------------------------------------------------------
// mb_valid_pattern_generator
//   Mainband TX valid-lane generator. Sends VALTRAIN bursts of 32'hF0F0_F0F0
//   (one 8-UI iteration per byte, bit 0 = first UI) for valid-lane training, and
//   in mission mode marks each data-valid frame with the same pattern.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_enable_generator    start/hold a burst; low aborts or releases it
//   i_enable_128          mode {cons,128}=01 -> ITER_128 burst
//   i_enable_cons         mode {cons,128}=10 -> CONSEC_16 burst (00/11 invalid)
//   i_data_valid          mission-mode frame valid (honoured only in IDLE)
//   o_TVLD_L[31:0]        TX valid-lane word (registered)
//   o_busy                burst in progress (registered)
//   o_done                burst complete, held until enable drops (registered)
//
// Optional macro VALID_ERR_INJECT_EN adds i_inject_err / i_inject_bit[4:0]:
//   a pulse in SEND flips one bit of the next pattern word only.
// -----------------------------------------------------------------------------
module mb_valid_pattern_generator #(
  parameter int unsigned ITER_128_CNT  = 128,
  parameter int unsigned ITER_CONS_CNT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable_generator,
  input  logic        i_enable_128,
  input  logic        i_enable_cons,
  input  logic        i_data_valid,
`ifdef VALID_ERR_INJECT_EN
  input  logic        i_inject_err,
  input  logic [4:0]  i_inject_bit,
`endif
  output logic [31:0] o_TVLD_L,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] VALID_PATTERN = 32'hF0F0_F0F0;
  localparam logic [1:0] MODE_128  = 2'b01;
  localparam logic [1:0] MODE_CONS = 2'b10;
  // Four 8-UI iterations fit in one 32-UI word.
  localparam logic [CNT_W-1:0] LAST_128  = CNT_W'(ITER_128_CNT / 4 - 1);
  localparam logic [CNT_W-1:0] LAST_CONS = CNT_W'(ITER_CONS_CNT / 4 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic [WORD_W-1:0] r_tvld, w_tvld_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [1:0]        w_mode_in;
  logic              w_mode_ok;
  logic [CNT_W-1:0]  w_last;

`ifdef VALID_ERR_INJECT_EN
  logic              r_inj_pend, w_inj_pend_nxt;
  logic [4:0]        r_inj_bit, w_inj_bit_nxt;
`endif

  assign w_mode_in = {i_enable_cons, i_enable_128};
  assign w_mode_ok = (w_mode_in == MODE_128) || (w_mode_in == MODE_CONS);
  // Burst length follows the mode latched at burst start, not the live inputs.
  assign w_last    = (r_mode == MODE_CONS) ? LAST_CONS : LAST_128;

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_tvld  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef VALID_ERR_INJECT_EN
      r_inj_pend <= 1'b0;
      r_inj_bit  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_tvld  <= w_tvld_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef VALID_ERR_INJECT_EN
      r_inj_pend <= w_inj_pend_nxt;
      r_inj_bit  <= w_inj_bit_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_tvld_nxt  = '0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
`ifdef VALID_ERR_INJECT_EN
    w_inj_pend_nxt = 1'b0;
    w_inj_bit_nxt  = r_inj_bit;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (i_enable_generator && w_mode_ok) begin
          w_state_nxt = S_SEND;
          w_cnt_nxt   = '0;
          w_mode_nxt  = w_mode_in;
        end else begin
          w_tvld_nxt = i_data_valid ? VALID_PATTERN : '0;
        end
      end
      S_SEND: begin
        if (!i_enable_generator) begin
          // Abort: back to IDLE with no done indication.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_tvld_nxt = VALID_PATTERN;
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
`ifdef VALID_ERR_INJECT_EN
          if (r_inj_pend) begin
            w_tvld_nxt = VALID_PATTERN ^ (WORD_W'(1) << r_inj_bit);
          end else if (i_inject_err) begin
            w_inj_pend_nxt = 1'b1;
            w_inj_bit_nxt  = i_inject_bit;
          end
`endif
          if (r_cnt == w_last) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
`ifdef VALID_ERR_INJECT_EN
            w_inj_pend_nxt = 1'b0;
`endif
          end
        end
      end
      S_DONE: begin
        if (!i_enable_generator) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_TVLD_L = r_tvld;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_mb_valid_pattern_generator.sv
// -----------------------------------------------------------------------------
// tb_mb_valid_pattern_generator
//   Directed bench for mb_valid_pattern_generator: reset, ITER_128 and CONSEC_16
//   bursts, invalid modes, abort/restart, mission-mode valid, async reset.
// -----------------------------------------------------------------------------
module tb_mb_valid_pattern_generator;

  localparam logic [31:0] PAT = 32'hF0F0_F0F0;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        en_128;
  logic        en_cons;
  logic        dv;
  logic [31:0] tvld;
  logic        busy;
  logic        done;
`ifdef VALID_ERR_INJECT_EN
  logic        inj_err;
  logic [4:0]  inj_bit;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  mb_valid_pattern_generator dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_enable_generator (en),
    .i_enable_128       (en_128),
    .i_enable_cons      (en_cons),
    .i_data_valid       (dv),
`ifdef VALID_ERR_INJECT_EN
    .i_inject_err       (inj_err),
    .i_inject_bit       (inj_bit),
`endif
    .o_TVLD_L           (tvld),
    .o_busy             (busy),
    .o_done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_tv, input logic e_busy,
                         input logic e_done);
    chk({tag, ".tvld"}, tvld, e_tv);
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after the start edge: expects n pattern words then done.
  task automatic expect_burst(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_out($sformatf("%s.w%0d", tag, i), PAT, 1'b1, 1'b0);
    end
    tick();
    chk_out({tag, ".done"}, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    en_128  = 1'b0;
    en_cons = 1'b0;
    dv      = 1'b0;
`ifdef VALID_ERR_INJECT_EN
    inj_err = 1'b0;
    inj_bit = 5'd0;
`endif

    // Reset state
    tick();
    tick();
    chk_out("reset", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("idle0", 32'h0, 1'b0, 1'b0);

    // ITER_128: 32 words, done held while enable high, cleared when it drops
    {en_cons, en_128} = 2'b01;
    en = 1'b1;
    tick();
    chk_out("i128.start", 32'h0, 1'b0, 1'b0);
    expect_burst("i128", 32);
    tick();
    chk_out("i128.hold", 32'h0, 1'b0, 1'b1);
    en = 1'b0;
    tick();
    chk_out("i128.release", 32'h0, 1'b0, 1'b0);

    // CONSEC_16: 4 words; mode inputs changed mid-burst must be ignored
    {en_cons, en_128} = 2'b10;
    en = 1'b1;
    tick();
    chk_out("cons.start", 32'h0, 1'b0, 1'b0);
    {en_cons, en_128} = 2'b01;
    expect_burst("cons", 4);
    en = 1'b0;
    tick();
    chk_out("cons.release", 32'h0, 1'b0, 1'b0);

    // Invalid modes: nothing starts
    en = 1'b1;
    {en_cons, en_128} = 2'b11;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk_out($sformatf("mode11.c%0d", i), 32'h0, 1'b0, 1'b0);
    end
    {en_cons, en_128} = 2'b00;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk_out($sformatf("mode00.c%0d", i), 32'h0, 1'b0, 1'b0);
    end
    en = 1'b0;
    tick();

    // Abort after 10 words, then a full restart
    {en_cons, en_128} = 2'b01;
    en = 1'b1;
    tick();
    chk_out("abort.start", 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out($sformatf("abort.w%0d", i), PAT, 1'b1, 1'b0);
    end
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("abort.post%0d", i), 32'h0, 1'b0, 1'b0);
    end
    en = 1'b1;
    tick();
    chk_out("restart.start", 32'h0, 1'b0, 1'b0);
    expect_burst("restart", 32);
    en = 1'b0;
    tick();
    chk_out("restart.release", 32'h0, 1'b0, 1'b0);

    // Mission mode: data valid honoured only in IDLE
    dv = 1'b1;
    tick();
    chk_out("dv.1a", PAT, 1'b0, 1'b0);
    dv = 1'b0;
    tick();
    chk_out("dv.0", 32'h0, 1'b0, 1'b0);
    dv = 1'b1;
    tick();
    chk_out("dv.1b", PAT, 1'b0, 1'b0);
    dv = 1'b0;
    {en_cons, en_128} = 2'b10;
    en = 1'b1;
    tick();
    chk_out("dvsend.start", 32'h0, 1'b0, 1'b0);
    dv = 1'b1;
    expect_burst("dvsend", 4);
    tick();
    chk_out("dvdone.hold", 32'h0, 1'b0, 1'b1);
    en = 1'b0;
    dv = 1'b0;
    tick();
    chk_out("dvsend.release", 32'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-burst
    {en_cons, en_128} = 2'b01;
    en = 1'b1;
    tick();
    tick();
    tick();
    chk_out("rstmid.pre", PAT, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rstmid.async", 32'h0, 1'b0, 1'b0);
    tick();
    en = 1'b0;
    chk_out("rstmid.held", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("rstmid.idle", 32'h0, 1'b0, 1'b0);
    {en_cons, en_128} = 2'b10;
    en = 1'b1;
    tick();
    chk_out("rstmid.start", 32'h0, 1'b0, 1'b0);
    expect_burst("rstmid", 4);
    en = 1'b0;
    tick();
    chk_out("rstmid.release", 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
